// File: rtl/vblank_update_arbiter_if.sv
// Bus bundle between the update requesters and the vblank update arbiter.
// Ports (signals):
//   vblnk        - vertical blanking flag (update window when high)
//   req          - per-requester level request, held until done
//   done         - per-requester one-cycle completion pulse
//   gnt          - one-hot (or zero) registered grant
//   busy         - high while any grant bit is high
//   frame_start  - one-cycle pulse after a vblnk rising edge
//   overrun      - one-cycle pulse, vblnk fell while a grant was held
//   timeout      - one-cycle pulse, grant revoked by the hold limit
//   frame_grants - grants issued since the last vblnk rising edge (saturating)
// master: requester side; slave: arbiter side.
interface vblank_update_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic             vblnk;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             frame_start;
    logic             overrun;
    logic             timeout;
    logic [7:0]       frame_grants;

    modport master (
        output vblnk, req, done,
        input  gnt, busy, frame_start, overrun, timeout, frame_grants
    );

    modport slave (
        input  vblnk, req, done,
        output gnt, busy, frame_start, overrun, timeout, frame_grants
    );
endinterface

// File: rtl/vblank_update_arbiter.sv
// Round-robin arbiter that hands out exclusive update grants to N_REQ
// requesters during the vertical blanking window of a VGA pipeline.
// A grant lasts until the owner signals done, drops its request, or the
// hold limit MAX_HOLD expires. Every release is followed by one idle cycle.
// Ports:
//   clk - pixel clock, rising edge
//   rst - synchronous, active-high reset
//   bus - vblank_update_arbiter_if.slave (vblnk/req/done in; gnt, busy,
//         frame_start, overrun, timeout, frame_grants out)
module vblank_update_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 1024
) (
    input logic                    clk,
    input logic                    rst,
    vblank_update_arbiter_if.slave bus
);

    localparam int unsigned       PTR_W      = $clog2(N_REQ);
    localparam int unsigned       HOLD_W     = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [PTR_W-1:0]  PTR_RESET  = PTR_W'(N_REQ - 1);
    localparam logic [7:0]        GRANTS_MAX = 8'd255;
    localparam logic [N_REQ-1:0]  ONE_HOT0   = N_REQ'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        grants_q, grants_d;
    logic              vblnk_q;
    logic              frame_start_q, frame_start_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              rise;
    logic              fall;
    logic              found;
    logic [PTR_W-1:0]  winner;
    logic              grant_issue;
    logic              rel_owner;
    logic              rel_hold;

    assign rise = bus.vblnk & ~vblnk_q;
    assign fall = ~bus.vblnk & vblnk_q;

    // In GRANTED, ptr_q holds the owner index, so only its done/req matter.
    assign rel_owner = bus.done[ptr_q] | ~bus.req[ptr_q];
    assign rel_hold  = (hold_q == HOLD_LAST);

    // Round-robin search starting one past the last winner.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] idx_p;
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        idx_p  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx   = (32'(ptr_q) + i) % N_REQ;
            idx_p = PTR_W'(idx);
            if (!found && bus.req[idx_p]) begin
                found  = 1'b1;
                winner = idx_p;
            end
        end
    end

    // Next-state, grant and pulse logic.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        grant_issue   = 1'b0;
        timeout_d     = 1'b0;
        overrun_d     = 1'b0;
        frame_start_d = rise;
        grants_d      = grants_q;

        unique case (state_q)
            IDLE: begin
                if (bus.vblnk && found) begin
                    grant_issue = 1'b1;
                    state_d     = GRANTED;
                    gnt_d       = ONE_HOT0 << winner;
                    ptr_d       = winner;
                    hold_d      = '0;
                end
            end
            GRANTED: begin
                hold_d    = hold_q + HOLD_W'(1);
                overrun_d = fall;
                if (rel_owner || rel_hold) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    // Owner-driven release takes precedence over the hold limit.
                    timeout_d = rel_hold && !rel_owner;
                end
            end
            default: state_d = IDLE;
        endcase

        // Per-frame grant count; a grant coinciding with the window start counts as 1.
        if (rise) begin
            grants_d = grant_issue ? 8'd1 : 8'd0;
        end else if (grant_issue && (grants_q != GRANTS_MAX)) begin
            grants_d = grants_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            ptr_q         <= PTR_RESET;
            hold_q        <= '0;
            grants_q      <= '0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            grants_q      <= grants_d;
            vblnk_q       <= bus.vblnk;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.busy         = |gnt_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;
    assign bus.frame_grants = grants_q;

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Directed self-checking bench for vblank_update_arbiter (N_REQ=4, MAX_HOLD=16).
// Expected grants are queued when a request pattern is driven and popped
// when the arbiter raises a grant.
module tb_vblank_update_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;

    vblank_update_arbiter_if #(.N_REQ(N_REQ)) vif ();

    vblank_update_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [N_REQ-1:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, then compare it against the scoreboard head.
    task automatic wait_grant(input string tag, output int cyc);
        logic [N_REQ-1:0] e;
        cyc = 0;
        while (vif.gnt == '0 && cyc < 50) begin
            step();
            cyc++;
        end
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_gnt"}, 32'(vif.gnt), 32'(e));
        check({tag, "_busy"}, 32'(vif.busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        int   hi;
        logic to_seen;

        rst       = 1'b1;
        vif.vblnk = 1'b0;
        vif.req   = '0;
        vif.done  = '0;
        repeat (3) step();

        // Reset state
        check("rst_gnt",          32'(vif.gnt),          32'd0);
        check("rst_busy",         32'(vif.busy),         32'd0);
        check("rst_frame_start",  32'(vif.frame_start),  32'd0);
        check("rst_overrun",      32'(vif.overrun),      32'd0);
        check("rst_timeout",      32'(vif.timeout),      32'd0);
        check("rst_frame_grants", 32'(vif.frame_grants), 32'd0);

        // Round robin over all four requesters, vblnk high out of reset
        vif.vblnk = 1'b1;
        vif.req   = 4'b1111;
        step();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k), cyc);
            check($sformatf("rr%0d_latency", k), 32'(cyc), 32'd1);
            check($sformatf("rr%0d_frame_grants", k), 32'(vif.frame_grants), 32'(k + 1));
            if (k == 0) check("rr_frame_start", 32'(vif.frame_start), 32'd1);
            step();
            step();
            vif.done = vif.gnt;
            step();
            vif.done = '0;
            if (k == 4) vif.req = '0;
            check($sformatf("rr%0d_release", k), 32'(vif.gnt), 32'd0);
            check($sformatf("rr%0d_release_busy", k), 32'(vif.busy), 32'd0);
            check($sformatf("rr%0d_no_timeout", k), 32'(vif.timeout), 32'd0);
        end

        // No grant outside the window; grant one cycle after window opens
        vif.vblnk = 1'b0;
        vif.req   = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            step();
            check("nowin_gnt", 32'(vif.gnt), 32'd0);
        end
        check("nowin_overrun", 32'(vif.overrun), 32'd0);
        vif.vblnk = 1'b1;
        exp_q.push_back(4'b0010);
        wait_grant("win", cyc);
        check("win_latency", 32'(cyc), 32'd1);
        check("win_frame_start", 32'(vif.frame_start), 32'd1);
        check("win_frame_grants", 32'(vif.frame_grants), 32'd1);
        step();
        check("win_frame_start_pulse", 32'(vif.frame_start), 32'd0);
        vif.req = '0;
        step();
        check("win_release", 32'(vif.gnt), 32'd0);

        // Hold limit: grant lasts MAX_HOLD cycles, non-owner done ignored
        vif.req = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant("hold", cyc);
        check("hold_latency", 32'(cyc), 32'd1);
        hi      = 1;
        to_seen = 1'b0;
        while (vif.gnt != '0 && hi < 40) begin
            vif.done = (hi == 5) ? 4'b0010 : 4'b0000;
            to_seen  = to_seen | vif.timeout;
            step();
            if (vif.gnt != '0) hi++;
        end
        vif.done = '0;
        check("hold_cycles", 32'(hi), 32'(MAX_HOLD));
        check("hold_timeout", 32'(vif.timeout), 32'd1);
        check("hold_early_timeout", 32'(to_seen), 32'd0);
        exp_q.push_back(4'b0001);
        wait_grant("regrant", cyc);
        check("regrant_latency", 32'(cyc), 32'd1);
        check("regrant_timeout_pulse", 32'(vif.timeout), 32'd0);
        vif.req = '0;
        step();
        check("reqdrop_release", 32'(vif.gnt), 32'd0);
        check("reqdrop_timeout", 32'(vif.timeout), 32'd0);

        // vblnk falls mid-grant: overrun pulse, grant kept until done
        vif.req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("ovr", cyc);
        vif.vblnk = 1'b0;
        step();
        check("ovr_pulse", 32'(vif.overrun), 32'd1);
        check("ovr_gnt_kept", 32'(vif.gnt), 32'b0100);
        step();
        check("ovr_pulse_end", 32'(vif.overrun), 32'd0);
        check("ovr_gnt_kept2", 32'(vif.gnt), 32'b0100);
        vif.done = 4'b0100;
        step();
        vif.done = '0;
        check("ovr_release", 32'(vif.gnt), 32'd0);
        check("ovr_no_timeout", 32'(vif.timeout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("ovr_wait_window", 32'(vif.gnt), 32'd0);
        end
        vif.vblnk = 1'b1;
        exp_q.push_back(4'b0100);
        wait_grant("ovr_next", cyc);
        check("ovr_next_latency", 32'(cyc), 32'd1);
        check("ovr_next_frame_start", 32'(vif.frame_start), 32'd1);
        check("ovr_next_frame_grants", 32'(vif.frame_grants), 32'd1);

        // Owner drops req; then 300 grants in one window saturate the count
        vif.req = 4'b0001;
        step();
        check("drop_release", 32'(vif.gnt), 32'd0);
        check("drop_timeout", 32'(vif.timeout), 32'd0);
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(4'b0001);
            wait_grant("sat", cyc);
            vif.done = 4'b0001;
            step();
            vif.done = '0;
        end
        check("sat_frame_grants", 32'(vif.frame_grants), 32'd255);

        // Reset mid-grant, then pointer restarts at index 0
        vif.req = 4'b1111;
        exp_q.push_back(4'b0010);
        wait_grant("midrst", cyc);
        rst = 1'b1;
        step();
        check("midrst_gnt",          32'(vif.gnt),          32'd0);
        check("midrst_busy",         32'(vif.busy),         32'd0);
        check("midrst_timeout",      32'(vif.timeout),      32'd0);
        check("midrst_overrun",      32'(vif.overrun),      32'd0);
        check("midrst_frame_start",  32'(vif.frame_start),  32'd0);
        check("midrst_frame_grants", 32'(vif.frame_grants), 32'd0);
        rst = 1'b0;
        exp_q.push_back(4'b0001);
        wait_grant("postrst", cyc);
        check("postrst_latency", 32'(cyc), 32'd1);
        check("postrst_frame_start", 32'(vif.frame_start), 32'd1);
        check("postrst_frame_grants", 32'(vif.frame_grants), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vblank_update_arbiter.md
VBLANK_UPDATE_ARBITER -- requirements
Module: vblank_update_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 1024, maximum grant length in clk cycles (>=2).
REQ-003 clk  in  1  pixel clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 vblnk  in  1  vertical blanking flag from the VGA timing pipeline; update window when high.
REQ-006 req  in  N_REQ  per-requester update request, level, held until done.
REQ-007 done  in  N_REQ  per-requester one-cycle completion pulse.
REQ-008 gnt  out  N_REQ  one-hot (or zero) grant, registered.
REQ-009 busy  out  1  high while any gnt bit is high.
REQ-010 frame_start  out  1  one-cycle pulse, vblnk rising edge seen.
REQ-011 overrun  out  1  one-cycle pulse, vblnk fell while a grant was held.
REQ-012 timeout  out  1  one-cycle pulse, grant revoked by MAX_HOLD.
REQ-013 frame_grants  out  8  grants issued since last vblnk rising edge, saturating at 255.

Function
REQ-014 States SHALL be IDLE and GRANTED; IDLE after reset.
REQ-015 vblnk SHALL be registered once (vblnk_q); rising edge = vblnk & ~vblnk_q; falling edge = ~vblnk & vblnk_q.
REQ-016 frame_start SHALL pulse in the cycle after the clock edge on which the rising edge is detected.
REQ-017 IDLE -> GRANTED SHALL occur only when vblnk=1 and req!=0 in the same cycle; gnt SHALL rise on the next clock edge (1-cycle latency).
REQ-018 Winner SHALL be chosen round-robin: search starts at index ptr+1 (mod N_REQ), first set req bit wins; ptr SHALL update to the winner index on grant.
REQ-019 In GRANTED, gnt SHALL stay constant until release.
REQ-020 Release SHALL occur on done[owner]=1, req[owner]=0, or hold counter reaching MAX_HOLD-1; gnt SHALL be 0 on the next edge and state SHALL return to IDLE.
REQ-021 Release by hold counter SHALL pulse timeout for one cycle; done/req release SHALL not.
REQ-022 After any release gnt SHALL remain 0 for at least one cycle before a new grant (IDLE dwell >=1 cycle).
REQ-023 Hold counter SHALL be $clog2(MAX_HOLD) bits, cleared on grant, incremented each GRANTED cycle.
REQ-024 done bits for non-owners, or in IDLE, SHALL be ignored.
REQ-025 vblnk falling edge while in GRANTED SHALL pulse overrun; the grant SHALL NOT be revoked and continues until REQ-020 release.
REQ-026 No new grant SHALL be issued while vblnk=0, even if req pending; pending req SHALL wait for the next window.
REQ-027 frame_grants SHALL clear to 0 on vblnk rising edge and increment by 1 per grant issued; if both in the same cycle, result SHALL be 1.
REQ-028 frame_grants SHALL saturate at 255, no wrap.
REQ-029 busy SHALL equal |gnt (combinational from registered gnt).

Reset
REQ-030 On rst=1: state IDLE, gnt=0, busy=0, frame_start=0, overrun=0, timeout=0, frame_grants=0, ptr=N_REQ-1 (first search starts at index 0), hold counter=0, vblnk_q=0.
REQ-031 rst asserted during GRANTED SHALL drop gnt on the next edge with no timeout/overrun pulse.
REQ-032 If vblnk=1 when rst deasserts, a rising edge SHALL be detected on the first cycle out of reset (vblnk_q=0).

Verification
REQ-033 vblnk=1, req=4'b1111, each owner pulses done 3 cycles after gnt -> gnt sequence 0001,0010,0100,1000,0001 with one idle cycle between grants; frame_grants counts 1..5.
REQ-034 vblnk=0, req=4'b0010 for 20 cycles, then vblnk=1 -> gnt stays 0 while vblnk=0; frame_start pulses; gnt=0010 one cycle after grant condition is first met.
REQ-035 MAX_HOLD=16, req[0] held without done -> gnt=0001 for exactly 16 cycles, timeout pulse once, gnt=0, then re-grant to 0001 after one idle cycle if alone.
REQ-036 Grant held, vblnk falls -> overrun pulses once, gnt retained until done; no new grant until vblnk=1 again.
REQ-037 Owner drops req without done -> release next edge, no timeout; 300 grants in one window -> frame_grants=255.
REQ-038 rst pulsed mid-grant -> all outputs 0 next edge; first post-reset grant with req=1111 goes to index 0.
